// File: rtl/video_pkg.sv
// video_pkg: shared BT.709 coefficients, clip limits, pipeline types and helpers for the 4:2:2 path
package video_pkg;
  localparam int LAT = 5;
  localparam int K [9] = '{47, 157, 16, -26, -86, 112, 112, -102, -10};
  localparam int Y_OFF = 16, C_OFF = 128;
  localparam int Y_MIN = 16, Y_MAX = 235, C_MIN = 16, C_MAX = 240;
  localparam logic [15:0] BLANK = 16'h8010;
  typedef struct packed { logic [7:0] y, cb, cr; } ycc_t;
  typedef struct packed { logic de, hs, vs, byp, ph; logic [15:0] raw; } ctl_t;
  function automatic logic [7:0] clip8(input logic signed [17:0] acc, input int off, input int lo, input int hi);
    int v;
    v = int'(acc >>> 8) + off;
    return 8'(v < lo ? lo : v > hi ? hi : v);
  endfunction
  function automatic logic [7:0] avg8(input logic [7:0] a, input logic [7:0] b);
    return 8'((9'(a) + 9'(b) + 9'd1) >> 1);
  endfunction
endpackage

// File: rtl/rgb_to_ycc422_if.sv
// rgb_to_ycc422_if: RGB pixel stream with strobes in, 4:2:2 stream with delayed strobes out
interface rgb_to_ycc422_if;
  logic        bypass, in_de, in_hs, in_vs;
  logic [23:0] in_rgb;
  logic        out_de, out_hs, out_vs;
  logic [15:0] out_data;
  modport master (output bypass, in_de, in_hs, in_vs, in_rgb, input out_de, out_hs, out_vs, out_data);
  modport slave (input bypass, in_de, in_hs, in_vs, in_rgb, output out_de, out_hs, out_vs, out_data);
endinterface

// File: rtl/csc_rgb2ycc.sv
// csc_rgb2ycc: two-stage BT.709 limited-range matrix, products then sum/round/clip
module csc_rgb2ycc
  import video_pkg::*;
#(
  parameter bit CLIP_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] i_rgb,
  output ycc_t        o_ycc
);
  localparam int YLO = CLIP_EN ? Y_MIN : 0;
  localparam int YHI = CLIP_EN ? Y_MAX : 255;
  localparam int CLO = CLIP_EN ? C_MIN : 0;
  localparam int CHI = CLIP_EN ? C_MAX : 255;
  logic signed [17:0] r_p [9];
  logic signed [17:0] w_acc [3];
  always_comb
    for (int c = 0; c < 3; c++) w_acc[c] = r_p[3*c] + r_p[3*c+1] + r_p[3*c+2] + 18'sd128;
  always_ff @(posedge clk) begin
    for (int i = 0; i < 9; i++) r_p[i] <= rst ? '0 : 18'(K[i] * int'(i_rgb[23-8*(i%3) -: 8]));
    o_ycc <= rst ? '0 : {clip8(w_acc[0], Y_OFF, YLO, YHI), clip8(w_acc[1], C_OFF, CLO, CHI),
                         clip8(w_acc[2], C_OFF, CLO, CHI)};
  end
endmodule

// File: rtl/rgb_to_ycc422.sv
// rgb_to_ycc422: RGB 4:4:4 to BT.709 YCbCr 4:2:2 with strobes and bypass kept LAT-cycle aligned
module rgb_to_ycc422
  import video_pkg::*;
#(
  parameter bit CHROMA_AVG = 1'b1,
  parameter bit CB_FIRST   = 1'b1,
  parameter bit CLIP_EN    = 1'b1
) (
  input logic            sys2_clk,
  input logic            sys2_rst,
  rgb_to_ycc422_if.slave vid
);
  logic       r_ph;
  ctl_t       w_ctl;
  ctl_t       r_ctl [LAT-1];
  ycc_t       w_ycc, r_a;
  logic       w_has;
  logic [7:0] w_cb, w_cr, w_first, w_second, w_own2, r_hold, r_c, r_y;
  csc_rgb2ycc #(.CLIP_EN(CLIP_EN)) u_csc (.clk(sys2_clk), .rst(sys2_rst), .i_rgb(vid.in_rgb), .o_ycc(w_ycc));
  assign w_ctl = '{de: vid.in_de, hs: vid.in_hs, vs: vid.in_vs, byp: vid.bypass, ph: r_ph, raw: vid.in_rgb[15:0]};
  // r_a holds the even pixel while its partner sits at the converter output
  assign w_has    = CHROMA_AVG && r_ctl[1].de;
  assign w_cb     = w_has ? avg8(r_a.cb, w_ycc.cb) : r_a.cb;
  assign w_cr     = w_has ? avg8(r_a.cr, w_ycc.cr) : r_a.cr;
  assign w_first  = CB_FIRST ? w_cb : w_cr;
  assign w_second = CB_FIRST ? w_cr : w_cb;
  assign w_own2   = CB_FIRST ? r_a.cr : r_a.cb;
  always_ff @(posedge sys2_clk) begin
    r_ph <= !sys2_rst && vid.in_de && !r_ph;
    r_ctl[0] <= sys2_rst ? '0 : w_ctl;
    for (int i = 1; i < LAT-1; i++) r_ctl[i] <= sys2_rst ? '0 : r_ctl[i-1];
    r_a <= sys2_rst ? '0 : w_ycc;
    r_hold <= sys2_rst ? '0 : w_second;
    r_c <= sys2_rst ? '0 : !r_ctl[2].ph ? w_first : CHROMA_AVG ? r_hold : w_own2;
    r_y <= sys2_rst ? '0 : r_a.y;
    vid.out_de <= !sys2_rst && r_ctl[LAT-2].de;
    vid.out_hs <= !sys2_rst && r_ctl[LAT-2].hs;
    vid.out_vs <= !sys2_rst && r_ctl[LAT-2].vs;
    vid.out_data <= sys2_rst ? '0 : r_ctl[LAT-2].byp ? r_ctl[LAT-2].raw : r_ctl[LAT-2].de ? {r_c, r_y} : BLANK;
  end
endmodule
